// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter types and encodings.
//   state_t        - transmitter FSM states
//   PAR_*          - cfg_parity encodings (11 also means none)
//   STOP_*         - cfg_stop encodings (11 also means two bits)
//   clamp_dbits()  - limits a requested data bit count to 5..max
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] STOP_1   = 2'b00;
    localparam logic [1:0] STOP_1P5 = 2'b01;
    localparam logic [1:0] STOP_2   = 2'b10;
    function automatic logic [3:0] clamp_dbits(input logic [3:0] d, input logic [3:0] max);
        return d < 4'd5 ? 4'd5 : d > max ? max : d;
    endfunction
endpackage

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: parity over the low dbits bits of data.
//   data   - payload, bits at or above dbits are ignored
//   dbits  - number of payload bits that take part
//   odd    - 1 selects odd parity, 0 even
//   parity - resulting parity bit
module uart_parity_calc #(
    parameter int DBIT_MAX = 9
) (
    input  logic [DBIT_MAX-1:0] data,
    input  logic [3:0]          dbits,
    input  logic                odd,
    output logic                parity
);
    always_comb begin
        parity = odd;
        for (int i = 0; i < DBIT_MAX; i++)
            parity = parity ^ (data[i] & (i < int'(dbits)));
    end
endmodule

// File: rtl/uart_tx_ext.sv
// uart_tx_ext: configurable UART transmitter (5..DBIT_MAX data bits,
// optional parity, 1/1.5/2 stop bits) driven by an oversampling strobe.
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   s_tick            - OS_RATE strobes per bit period
//   tx_valid/tx_ready - frame handshake, accepted only in IDLE
//   tx_data           - payload, LSB first
//   cfg_dbits/cfg_parity/cfg_stop - frame format, captured at acceptance
//   tx, tx_busy, tx_done_tick     - serial line, busy flag, end-of-frame pulse
// Parity support is compiled in only when UART_TX_PARITY_EN is defined;
// otherwise every frame is sent without parity.
module uart_tx_ext
    import uart_pkg::*;
#(
    parameter int DBIT_MAX = 9,
    parameter int OS_RATE  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_tick,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [DBIT_MAX-1:0] tx_data,
    input  logic [3:0]          cfg_dbits,
    input  logic [1:0]          cfg_parity,
    input  logic [1:0]          cfg_stop,
    output logic                tx,
    output logic                tx_busy,
    output logic                tx_done_tick
);
    localparam int TW = $clog2(2 * OS_RATE);
    localparam int BW = $clog2(DBIT_MAX);
    state_t              state;
    logic [TW-1:0]       tick_cnt;
    logic [BW-1:0]       bit_cnt;
    logic [DBIT_MAX-1:0] data_r;
    logic [3:0]          dbits_r;
    logic [1:0]          stop_r;
    logic [3:0]          dbits_c;
    logic [TW-1:0]       stop_last;
    logic                bit_end;
    assign dbits_c   = clamp_dbits(cfg_dbits, 4'(DBIT_MAX));
    assign bit_end   = tick_cnt == TW'(OS_RATE - 1);
    assign stop_last = stop_r == STOP_1   ? TW'(OS_RATE - 1) :
                       stop_r == STOP_1P5 ? TW'(3 * OS_RATE / 2 - 1) : TW'(2 * OS_RATE - 1);
    assign tx_ready  = state == IDLE;
    assign tx_busy   = !tx_ready;
`ifdef UART_TX_PARITY_EN
    logic par_en_r, par_bit_r, par_bit_c;
    // Parity is taken from the payload at acceptance so the shifting data
    // register never has to be re-scanned.
    uart_parity_calc #(.DBIT_MAX(DBIT_MAX)) u_parity (
        .data   (tx_data),
        .dbits  (dbits_c),
        .odd    (cfg_parity == PAR_ODD),
        .parity (par_bit_c)
    );
`else
    logic unused_parity;
    assign unused_parity = ^cfg_parity;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            data_r       <= '0;
            dbits_r      <= '0;
            stop_r       <= '0;
            tx           <= 1'b1;
            tx_done_tick <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_r     <= 1'b0;
            par_bit_r    <= 1'b0;
`endif
        end else begin
            tx_done_tick <= 1'b0;
            case (state)
                IDLE: if (tx_valid) begin
                    state    <= START;
                    tx       <= 1'b0;
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    data_r   <= tx_data;
                    dbits_r  <= dbits_c;
                    stop_r   <= cfg_stop;
`ifdef UART_TX_PARITY_EN
                    par_en_r  <= cfg_parity == PAR_EVEN || cfg_parity == PAR_ODD;
                    par_bit_r <= par_bit_c;
`endif
                end
                START: if (s_tick) begin
                    if (bit_end) begin
                        tick_cnt <= '0;
                        state    <= DATA;
                        tx       <= data_r[0];
                    end else
                        tick_cnt <= tick_cnt + 1'b1;
                end
                DATA: if (s_tick) begin
                    if (bit_end) begin
                        tick_cnt <= '0;
                        if (bit_cnt == BW'(dbits_r - 4'd1)) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                            tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
                            if (par_en_r) begin
                                state <= PARITY;
                                tx    <= par_bit_r;
                            end
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            data_r  <= data_r >> 1;
                            tx      <= data_r[1];
                        end
                    end else
                        tick_cnt <= tick_cnt + 1'b1;
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (s_tick) begin
                    if (bit_end) begin
                        tick_cnt <= '0;
                        state    <= STOP;
                        tx       <= 1'b1;
                    end else
                        tick_cnt <= tick_cnt + 1'b1;
                end
`endif
                STOP: if (s_tick) begin
                    if (tick_cnt == stop_last) begin
                        tick_cnt     <= '0;
                        state        <= IDLE;
                        tx_done_tick <= 1'b1;
                    end else
                        tick_cnt <= tick_cnt + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_ext.sv
// tb_uart_tx_ext: directed, table-driven bench for uart_tx_ext.
module tb_uart_tx_ext;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int OS = 16;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [8:0] tx_data = '0;
    logic [3:0] cfg_dbits = 4'd8;
    logic [1:0] cfg_parity = 2'b00;
    logic [1:0] cfg_stop = 2'b00;
    logic       tx, tx_busy, tx_done_tick;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0] data;
        logic [3:0] dbits;
        logic [1:0] par;
        logic [1:0] stp;
        int         nd;
        logic       pbit;
        int         stop_ticks;
    } vec_t;
    vec_t vecs[7];

    uart_tx_ext #(.DBIT_MAX(9), .OS_RATE(OS)) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .cfg_dbits(cfg_dbits),
        .cfg_parity(cfg_parity), .cfg_stop(cfg_stop), .tx(tx),
        .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Follows one frame from the sample just after its acceptance edge to its
    // done pulse; s_tick is irregular so counters must freeze between ticks.
    task automatic monitor(input string tag, input logic [8:0] d, input int nd,
                           input bit has_par, input logic pbit,
                           input int stop_ticks, input bit keep_valid);
        logic seq[0:15];
        int nb, total, n, bad, first_n, done_seen;
        seq[0] = 1'b0;
        for (int i = 0; i < nd; i++) seq[1 + i] = d[i];
        if (has_par) seq[1 + nd] = pbit;
        nb = 1 + nd + (has_par ? 1 : 0);
        total = nb * OS + stop_ticks;
        n = 0; bad = 0; first_n = -1; done_seen = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic exp_tx;
            @(negedge clk);
            if (cyc == 0) begin
                tx_valid   = keep_valid;
                tx_data    = ~d;
                cfg_dbits  = 4'd5;
                cfg_parity = 2'b01;
                cfg_stop   = 2'b11;
            end
            if (n == total) begin
                s_tick = 1'b0;
                done_seen = 1;
                check({tag, " done_pulse"}, {tx_done_tick, tx_busy, tx_ready, tx}, 4'b1011);
                break;
            end
            exp_tx = n < nb * OS ? seq[n / OS] : 1'b1;
            if (tx !== exp_tx || tx_done_tick !== 1'b0 || tx_busy !== 1'b1 || tx_ready !== 1'b0) begin
                bad++;
                if (first_n < 0) first_n = n;
            end
            s_tick = (cyc % 3) != 0;
            if (s_tick) n++;
        end
        check({tag, " done_reached"}, done_seen, 1);
        check({tag, " bad_samples"}, bad, 0);
        if (bad != 0) $display("  %s first bad sample at tick %0d", tag, first_n);
    endtask

    task automatic start(input vec_t v);
        @(negedge clk);
        s_tick     = 1'b0;
        tx_data    = v.data;
        cfg_dbits  = v.dbits;
        cfg_parity = v.par;
        cfg_stop   = v.stp;
        tx_valid   = 1'b1;
    endtask

    function automatic bit has_par(input vec_t v);
        return PAR_EN && (v.par == 2'b01 || v.par == 2'b10);
    endfunction

    task automatic run_vec(input int i, input bit keep_valid);
        start(vecs[i]);
        monitor($sformatf("vec%0d", i), vecs[i].data, vecs[i].nd, has_par(vecs[i]),
                vecs[i].pbit, vecs[i].stop_ticks, keep_valid);
    endtask

    initial begin
        vecs[0] = '{9'h055, 4'd8,  2'b00, 2'b00, 8, 1'b0, 16};
        vecs[1] = '{9'h041, 4'd7,  2'b01, 2'b00, 7, 1'b0, 16};
        vecs[2] = '{9'h003, 4'd8,  2'b10, 2'b01, 8, 1'b1, 24};
        vecs[3] = '{9'h1A5, 4'd15, 2'b01, 2'b10, 9, 1'b1, 32};
        vecs[4] = '{9'h0FF, 4'd2,  2'b11, 2'b11, 5, 1'b0, 32};
        vecs[5] = '{9'h1C1, 4'd6,  2'b01, 2'b00, 6, 1'b1, 16};
        vecs[6] = '{9'h000, 4'd5,  2'b10, 2'b01, 5, 1'b1, 24};

        tx_valid = 1'b1;
        s_tick   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_ready", tx_ready, 1);
        check("reset_busy", tx_busy, 0);
        check("reset_done", tx_done_tick, 0);
        tx_valid = 1'b0;
        s_tick   = 1'b0;
        reset    = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_tx", tx, 1);

        for (int i = 0; i < 7; i++) run_vec(i, 1'b0);

        // Valid held through a frame and dropped at its done pulse: nothing queued.
        run_vec(0, 1'b1);
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("no_queue_ready", tx_ready, 1);
        check("no_queue_tx", tx, 1);

        // Back-to-back: second frame starts on the edge right after done.
        run_vec(0, 1'b1);
        tx_data    = vecs[5].data;
        cfg_dbits  = vecs[5].dbits;
        cfg_parity = vecs[5].par;
        cfg_stop   = vecs[5].stp;
        @(posedge clk);
        #1;
        check("b2b_start_tx", tx, 0);
        check("b2b_start_busy", tx_busy, 1);
        monitor("b2b_second", vecs[5].data, vecs[5].nd, has_par(vecs[5]),
                vecs[5].pbit, vecs[5].stop_ticks, 1'b0);

        // Reset in the middle of data bit 3.
        start(vecs[0]);
        @(negedge clk);
        tx_valid = 1'b0;
        for (int t = 0; t < OS * 4 + OS / 2; t++) begin
            s_tick = 1'b1;
            @(negedge clk);
        end
        check("pre_reset_busy", tx_busy, 1);
        check("pre_reset_bit3", tx, 0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_tx", tx, 1);
        check("abort_ready", tx_ready, 1);
        check("abort_done", tx_done_tick, 0);
        reset = 1'b0;
        begin
            int seen = 0;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (tx_done_tick || !tx) seen++;
            end
            check("abort_quiet", seen, 0);
        end
        s_tick = 1'b0;
        run_vec(2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
